// File: rtl/hyst_result_writer_if.sv
// Bus interfaces for hyst_result_writer.
//   hyst_col_if : finished-column channel from the hysteresis stage
//                 (master = hysteresis stage, slave = result writer).
//   hyst_mem_if : byte write port into the output-image memory
//                 (master = result writer, slave = memory).
`timescale 1ns/1ps

interface hyst_col_if #(
  parameter int NUM_PIX    = 10,
  parameter int ADDR_WIDTH = 20
);
  logic                        col_valid;
  logic [NUM_PIX-1:0][7:0]     col_data;   // element 0 = top pixel
  logic [ADDR_WIDTH-1:0]       col_addr;   // address of pixel 0
  logic                        col_ready;

  modport master (
    output col_valid,
    output col_data,
    output col_addr,
    input  col_ready
  );

  modport slave (
    input  col_valid,
    input  col_data,
    input  col_addr,
    output col_ready
  );
endinterface

interface hyst_mem_if #(
  parameter int ADDR_WIDTH = 20
);
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [7:0]            mem_wdata;
  logic                  mem_ready;

  modport master (
    output mem_wr_en,
    output mem_addr,
    output mem_wdata,
    input  mem_ready
  );

  modport slave (
    input  mem_wr_en,
    input  mem_addr,
    input  mem_wdata,
    output mem_ready
  );
endinterface

// File: rtl/hyst_result_writer.sv
// hyst_result_writer: captures finished pixel columns from the hysteresis
// stage into a holding slot, moves them to an active slot and streams them
// one byte per accepted cycle into the output-image memory, walking down the
// column by ROW_STRIDE per pixel. A column offered while the holding slot is
// full is dropped and flagged in the sticky overflow bit.
//
// Optional feature macro: HYST_BINARIZE_EN
//   defined   -> every non-zero pixel is written as 8'hFF, zero as 8'h00
//   undefined -> pixels are written unchanged
`timescale 1ns/1ps

module hyst_result_writer #(
  parameter int NUM_PIX    = 10,
  parameter int ADDR_WIDTH = 20,
  parameter int ROW_STRIDE = 640
) (
  input  logic        clk,
  input  logic        rst,
  hyst_col_if.slave   col,
  hyst_mem_if.master  mem,
  output logic        writer_idle,
  output logic        overflow,
  output logic [15:0] cols_written
);

  localparam int                    IDX_W    = (NUM_PIX > 1) ? $clog2(NUM_PIX) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(NUM_PIX - 1);
  localparam logic [ADDR_WIDTH-1:0] STRIDE   = ADDR_WIDTH'(ROW_STRIDE);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Holding slot (filled by the upstream stage) and active slot (being written).
  logic [NUM_PIX-1:0][7:0] r_hold_data;
  logic [ADDR_WIDTH-1:0]   r_hold_base;
  logic                    r_hold_valid;
  logic [NUM_PIX-1:0][7:0] r_act_data;

  // Write pointer and registered memory outputs. The active base address is
  // not kept separately: r_mem_addr starts at it and accumulates ROW_STRIDE,
  // which equals base + idx*ROW_STRIDE modulo 2^ADDR_WIDTH.
  logic [IDX_W-1:0]      r_idx;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [7:0]            r_mem_wdata;
  logic                  r_overflow;
  logic [15:0]           r_cols_written;

  logic             w_capture;
  logic             w_drop;
  logic             w_load;
  logic             w_accept;
  logic             w_last;
  logic             w_col_done;
  logic             w_wr_en;
  logic             w_idle;
  logic [IDX_W-1:0] w_idx_next;

  // Output pixel mapping; the binarised build collapses strong/weak edges.
  function automatic logic [7:0] f_pix_out(input logic [7:0] pix);
`ifdef HYST_BINARIZE_EN
    return (pix != 8'h00) ? 8'hFF : 8'h00;
`else
    return pix;
`endif
  endfunction

  assign w_capture  = col.col_valid && !r_hold_valid;
  assign w_drop     = col.col_valid &&  r_hold_valid;
  assign w_accept   = (r_state == S_WRITE) && mem.mem_ready;
  assign w_last     = (r_idx == LAST_IDX);
  assign w_col_done = w_accept && w_last;
  assign w_idx_next = r_idx + IDX_W'(1);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking (=) here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode.
  // NOTE: every combinational output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (r_hold_valid) w_state_next = S_LOAD;
      end
      S_LOAD: begin
        w_state_next = S_WRITE;
      end
      S_WRITE: begin
        if (w_col_done) begin
          // A column captured in this same cycle still counts as waiting.
          w_state_next = (r_hold_valid || w_capture) ? S_LOAD : S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded control outputs.
  always_comb begin
    w_wr_en = 1'b0;
    w_load  = 1'b0;
    w_idle  = 1'b0;
    unique case (r_state)
      S_IDLE:  w_idle  = !r_hold_valid;
      S_LOAD:  w_load  = 1'b1;
      S_WRITE: w_wr_en = 1'b1;
      default: w_idle  = 1'b0;
    endcase
  end

  // Holding-slot occupancy; a capture in the LOAD cycle refills the slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_valid <= 1'b0;
    end else if (w_capture) begin
      r_hold_valid <= 1'b1;
    end else if (w_load) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Column payload storage for both slots.
  // NOTE: the pixel/address storage has no reset; it is only ever read while
  // guarded by r_hold_valid or the FSM, so clearing it would add reset fan-out
  // for no functional effect.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold_data <= col.col_data;
      r_hold_base <= col.col_addr;
    end
    if (w_load) begin
      r_act_data <= r_hold_data;
    end
  end

  // Pixel pointer and registered address/data; held while memory stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx       <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 8'h00;
    end else if (w_load) begin
      r_idx       <= '0;
      r_mem_addr  <= r_hold_base;
      r_mem_wdata <= f_pix_out(r_hold_data[0]);
    end else if (w_accept) begin
      if (w_last) begin
        r_idx <= '0;
      end else begin
        r_idx       <= w_idx_next;
        r_mem_addr  <= r_mem_addr + STRIDE;
        r_mem_wdata <= f_pix_out(r_act_data[w_idx_next]);
      end
    end
  end

  // Sticky drop flag and completed-column counter (wraps at 16 bits).
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow     <= 1'b0;
      r_cols_written <= 16'h0000;
    end else begin
      if (w_drop) r_overflow <= 1'b1;
      if (w_col_done) r_cols_written <= r_cols_written + 16'h0001;
    end
  end

  assign col.col_ready = !r_hold_valid;
  assign mem.mem_wr_en = w_wr_en;
  assign mem.mem_addr  = r_mem_addr;
  assign mem.mem_wdata = r_mem_wdata;
  assign writer_idle   = w_idle;
  assign overflow      = r_overflow;
  assign cols_written  = r_cols_written;

endmodule

// File: tb/tb_hyst_result_writer.sv
// Self-checking bench for hyst_result_writer: directed scenarios followed by
// randomized traffic, compared against a column-level reference model
// (expected write stream queue plus slot/busy bookkeeping).
`timescale 1ns/1ps

module tb_hyst_result_writer;

  localparam int NUM_PIX = 10;
  localparam int AW      = 20;
  localparam int STRIDE  = 640;

  typedef struct packed {
    logic [NUM_PIX-1:0][7:0] data;
    logic [AW-1:0]           base;
  } col_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        writer_idle;
  logic        overflow;
  logic [15:0] cols_written;

  always #5 clk = ~clk;

  hyst_col_if #(.NUM_PIX(NUM_PIX), .ADDR_WIDTH(AW)) col_bus ();
  hyst_mem_if #(.ADDR_WIDTH(AW))                    mem_bus ();

  hyst_result_writer #(
    .NUM_PIX   (NUM_PIX),
    .ADDR_WIDTH(AW),
    .ROW_STRIDE(STRIDE)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .col         (col_bus.slave),
    .mem         (mem_bus.master),
    .writer_idle (writer_idle),
    .overflow    (overflow),
    .cols_written(cols_written)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit          m_hold_full;  // a column waits in the holding slot
  int          m_wr_left;    // bytes of the active column still to write
  bit          m_in_load;    // current cycle moves hold -> active
  bit          m_ovf;
  logic [15:0] m_cols;
  wr_t         m_exp_q[$];   // every byte still owed to memory, in order

  function automatic logic [7:0] exp_pix(input logic [7:0] p);
`ifdef HYST_BINARIZE_EN
    return (p != 8'h00) ? 8'hFF : 8'h00;
`else
    return p;
`endif
  endfunction

  task automatic model_step(input bit v, input col_t c, input bit rdy, input bit r);
    bit accept;
    bit next_load;
    bit next_hold;
    if (r) begin
      m_hold_full = 0;
      m_wr_left   = 0;
      m_in_load   = 0;
      m_ovf       = 0;
      m_cols      = 16'h0;
      m_exp_q.delete();
      return;
    end
    accept    = v && !m_hold_full;
    next_hold = m_hold_full;
    next_load = 0;
    if (m_in_load) begin
      m_wr_left = NUM_PIX;
      next_hold = 0;
    end else if (m_wr_left > 0) begin
      if (rdy) begin
        m_wr_left--;
        if (m_wr_left == 0) begin
          m_cols++;
          next_load = m_hold_full || accept;
        end
      end
    end else begin
      next_load = m_hold_full;
    end
    if (accept) begin
      next_hold = 1;
      for (int i = 0; i < NUM_PIX; i++) begin
        wr_t w;
        w.addr = AW'(32'(c.base) + i * STRIDE);
        w.data = exp_pix(c.data[i]);
        m_exp_q.push_back(w);
      end
    end
    if (v && m_hold_full) m_ovf = 1;
    m_in_load   = next_load;
    m_hold_full = next_hold;
  endtask

  // One clock cycle: drive inputs, score any write accepted this cycle,
  // advance the model at the edge, then compare outputs on the falling edge.
  task automatic step(input bit v, input col_t c, input bit rdy, input bit r);
    col_bus.col_valid = v;
    col_bus.col_data  = c.data;
    col_bus.col_addr  = c.base;
    mem_bus.mem_ready = rdy;
    rst               = r;
    if (!r && mem_bus.mem_wr_en === 1'b1 && rdy) begin
      if (m_exp_q.size() == 0) begin
        check("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = m_exp_q.pop_front();
        check("wr_addr", 32'(mem_bus.mem_addr), 32'(e.addr));
        check("wr_data", 32'(mem_bus.mem_wdata), 32'(e.data));
      end
    end
    @(posedge clk);
    model_step(v, c, rdy, r);
    @(negedge clk);
    check("col_ready",    32'(col_bus.col_ready), 32'(!m_hold_full));
    check("mem_wr_en",    32'(mem_bus.mem_wr_en), 32'(m_wr_left > 0));
    check("writer_idle",  32'(writer_idle), 32'(!m_hold_full && m_wr_left == 0 && !m_in_load));
    check("overflow",     32'(overflow), 32'(m_ovf));
    check("cols_written", 32'(cols_written), 32'(m_cols));
  endtask

  col_t none_c;

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, none_c, 1'b1, 1'b0);
  endtask

  // Run with mem_ready=1 until the model has nothing left, bounded.
  task automatic drain(input string tag);
    int budget;
    budget = 100;
    while ((m_hold_full || m_wr_left > 0 || m_in_load) && budget > 0) begin
      step(1'b0, none_c, 1'b1, 1'b0);
      budget--;
    end
    check({tag, "_drain_timeout"}, 32'(budget > 0), 32'd1);
    step(1'b0, none_c, 1'b1, 1'b0);
    check({tag, "_idle"}, 32'(writer_idle), 32'd1);
    check({tag, "_exp_q_empty"}, 32'(m_exp_q.size()), 32'd0);
  endtask

  function automatic col_t seq_col(input logic [AW-1:0] base, input logic [7:0] start);
    col_t c;
    c.base = base;
    for (int i = 0; i < NUM_PIX; i++) c.data[i] = start + 8'(i);
    return c;
  endfunction

  initial begin
    col_t ca;
    col_t cb;
    col_t cc;
    col_t cr;
    none_c = '0;

    // Reset, then single column at cycle 5 (writes expected on cycles 8..17).
    step(1'b0, none_c, 1'b1, 1'b1);
    step(1'b0, none_c, 1'b1, 1'b1);
    check("reset_mem_addr",  32'(mem_bus.mem_addr), 32'd0);
    check("reset_mem_wdata", 32'(mem_bus.mem_wdata), 32'd0);
    idle_steps(3);
    ca = seq_col(20'h00100, 8'h01);
    step(1'b1, ca, 1'b1, 1'b0);
    idle_steps(2);
    check("single_first_addr", 32'(mem_bus.mem_addr), 32'h00100);
    idle_steps(9);
    check("single_last_addr", 32'(mem_bus.mem_addr), 32'h01780);
    check("single_last_data", 32'(mem_bus.mem_wdata), 32'(exp_pix(8'h0A)));
    idle_steps(1);
    check("single_cols", 32'(cols_written), 32'd1);
    drain("single");

    // Back-pressure: mem_ready low every other cycle.
    step(1'b1, ca, 1'b1, 1'b0);
    for (int i = 0; i < 40; i++) step(1'b0, none_c, i[0], 1'b0);
    drain("bp");

    // Back-to-back: A at 0, B at 4 accepted, C at 6 dropped.
    ca = seq_col(20'h02000, 8'h10);
    cb = seq_col(20'h03000, 8'h20);
    cc = seq_col(20'h04000, 8'h30);
    step(1'b1, ca, 1'b1, 1'b0);
    idle_steps(3);
    step(1'b1, cb, 1'b1, 1'b0);
    check("b2b_col_ready_after_b", 32'(col_bus.col_ready), 32'd0);
    idle_steps(1);
    step(1'b1, cc, 1'b1, 1'b0);
    check("b2b_overflow", 32'(overflow), 32'd1);
    drain("b2b");
    check("b2b_cols", 32'(cols_written), 32'd4);

    // Address wrap modulo 2^20.
    ca = seq_col(20'hFFF00, 8'h40);
    step(1'b1, ca, 1'b1, 1'b0);
    idle_steps(3);
    check("wrap_pix1_addr", 32'(mem_bus.mem_addr), 32'h00180);
    drain("wrap");

    // Reset after 4 bytes, then a fresh column from idx 0.
    ca = seq_col(20'h05000, 8'h50);
    step(1'b1, ca, 1'b1, 1'b0);
    idle_steps(6);
    step(1'b0, none_c, 1'b1, 1'b1);
    check("midrst_wr_en", 32'(mem_bus.mem_wr_en), 32'd0);
    check("midrst_cols", 32'(cols_written), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    cb = seq_col(20'h06000, 8'h60);
    step(1'b1, cb, 1'b1, 1'b0);
    drain("midrst");

    // Binarisation pattern (values pass through unchanged without the macro).
    cr = '0;
    cr.base    = 20'h07000;
    cr.data[1] = 8'h80;
    cr.data[2] = 8'hFF;
    cr.data[3] = 8'h01;
    step(1'b1, cr, 1'b1, 1'b0);
    drain("binarize");

    // Randomized traffic with stalls, drops and rare resets.
    for (int i = 0; i < 2000; i++) begin
      bit v;
      bit rdy;
      bit r;
      v     = ($urandom_range(0, 3) == 0);
      rdy   = ($urandom_range(0, 3) != 0);
      r     = ($urandom_range(0, 399) == 0);
      cr.base = AW'($urandom);
      for (int p = 0; p < NUM_PIX; p++)
        cr.data[p] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      step(v, cr, rdy, r);
    end
    drain("random");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hyst_result_writer.md
Name: hyst_result_writer

Overview:
Consumer on the far side of the hysteresis stage's column-result interface.
- Captures each finished 10-pixel column from the hysteresis stage.
- Double-buffers it and serialises it one byte per cycle into the output-image memory write port.
- Applies per-pixel address generation and a ready handshake from memory.
- Back-pressures the upstream stage through col_ready.

Parameters:
NUM_PIX, 10, pixels per column result (indices 0..NUM_PIX-1)
ADDR_WIDTH, 20, output memory address width
ROW_STRIDE, 640, address increment between vertically adjacent pixels

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
col_valid  in  1  one-cycle pulse: col_data/col_addr hold a finished column
col_data  in  NUM_PIX x 8  column pixels, element 0 = top pixel
col_addr  in  ADDR_WIDTH  memory address of pixel 0 of this column
col_ready  out  1  holding slot free; a column offered now is accepted
mem_wr_en  out  1  write request to output memory
mem_addr  out  ADDR_WIDTH  write address
mem_wdata  out  8  write data
mem_ready  in  1  memory accepts the current write this cycle
writer_idle  out  1  no column held or in flight
overflow  out  1  sticky: a column arrived while col_ready=0
cols_written  out  16  count of fully written columns

Behaviour:
Reset, synchronous, rst=1 at a clock edge:
- state=IDLE; hold_valid=0; idx=0.
- mem_wr_en=0, mem_addr=0, mem_wdata=0.
- col_ready=1, writer_idle=1, overflow=0, cols_written=0.
- Reset mid-write abandons the column: mem_wr_en is 0 from the cycle after the reset edge.

Storage:
- Holding slot: NUM_PIX bytes plus base address, with hold_valid.
- Active slot: NUM_PIX bytes plus base address.
- col_ready = !hold_valid (combinational).

Capture:
- col_valid && col_ready → hold slot loaded, hold_valid=1 next cycle.
- col_valid && !col_ready → column dropped, overflow set; it clears only on rst.

States:
- IDLE: writer_idle = !hold_valid. If hold_valid → LOAD.
- LOAD (1 cycle):
  - Active slot ← hold slot; hold_valid cleared; idx=0.
  - A capture in the same cycle wins: hold_valid stays 1 with the new column.
  - → WRITE.
- WRITE:
  - mem_wr_en=1, mem_addr = active_base + idx*ROW_STRIDE, truncated modulo 2^ADDR_WIDTH.
  - mem_wdata = active[idx].
  - Outputs held stable while mem_ready=0.
  - On mem_ready, idx increments.
  - On mem_ready with idx==NUM_PIX-1: cols_written increments (wraps 0xFFFF→0); next state is LOAD if hold_valid (including a capture this same cycle), else IDLE.

mem_addr/mem_wdata are registered. mem_wr_en is decoded from state.

Latency with mem_ready held 1:
- col_valid at cycle N (in IDLE) → mem_wr_en first high at N+3.
- Last byte at N+3+NUM_PIX-1.
- With a column waiting in hold, the next column's first write comes 1 cycle (LOAD) after the previous last write.

Throughput: one column per NUM_PIX+1 cycles.

Optional Feature:
Macro HYST_BINARIZE_EN.
- Defined: mem_wdata = 8'hFF if active[idx] != 0, else 8'h00 (strong/weak edges collapsed to binary output).
- Undefined: mem_wdata = active[idx] unchanged.
- Handshake, timing and addressing are identical either way.

Test Plan:
- Reset then single column: col_addr=0x00100, col_data=0x01..0x0A, mem_ready=1, col_valid at cycle 5 → mem_wr_en high cycles 8–17; addresses 0x00100, 0x00380, …, 0x00100+9*640=0x01780; data 0x01..0x0A; cols_written=1; writer_idle=1 at cycle 18.
- Back-pressure: same column, mem_ready low on every other cycle → each addr/data pair held until accepted, 10 writes total, no duplicates, col_ready=1 throughout.
- Back-to-back: column A at cycle 0, column B at cycle 4 (accepted, col_ready=0 after), column C at cycle 6 → C dropped, overflow=1; A then B written with exactly one LOAD cycle between them; cols_written=2.
- Address wrap: col_addr=0xFFF00, ADDR_WIDTH=20 → pixel 1 address = 0x00180 (mod 2^20).
- Reset mid-write: rst=1 after 4 bytes of a column → mem_wr_en=0 the next cycle, cols_written=0, overflow=0; a new column afterwards is written starting from idx 0.
- HYST_BINARIZE_EN defined: col_data={0x00,0x80,0xFF,0x01,0,0,0,0,0,0} → mem_wdata sequence 0x00,0xFF,0xFF,0xFF,0x00×6.
